// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller for a 5-stage MIPS pipeline with a mult/div unit.
// Tracks in-flight writers (E, M, W) to derive forward selects, stall and MD sequencing.
module hazard_ctrl #(
   parameter int MULT_CYC = 5,
   parameter int DIV_CYC  = 10
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [4:0] rs_d,
   input  logic [4:0] rt_d,
   input  logic [1:0] tuse_rs_d,
   input  logic [1:0] tuse_rt_d,
   input  logic [4:0] dst_d,
   input  logic [1:0] tnew_d,
   input  logic [1:0] src_d,
   input  logic       md_use_d,
   input  logic [1:0] md_op_d,
   output logic       stall,
   output logic [2:0] fwd_rsd,
   output logic [2:0] fwd_rtd,
   output logic [2:0] fwd_rse,
   output logic [2:0] fwd_rte,
   output logic [2:0] fwd_rtm,
   output logic       md_start,
   output logic       md_busy
);

   localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   localparam logic [1:0] SRC_ALU  = 2'd0;
   localparam logic [1:0] SRC_LOAD = 2'd1;
   localparam logic [1:0] SRC_PC8  = 2'd2;
   localparam logic [1:0] SRC_MD   = 2'd3;

   localparam logic [1:0] MD_MULT = 2'd1;
   localparam logic [1:0] MD_DIV  = 2'd2;

   localparam logic [2:0] SEL_REG    = 3'd0;
   localparam logic [2:0] SEL_AO_M   = 3'd1;
   localparam logic [2:0] SEL_WD     = 3'd2;
   localparam logic [2:0] SEL_PC8_E  = 3'd3;
   localparam logic [2:0] SEL_PC8_M  = 3'd4;
   localparam logic [2:0] SEL_PC8_W  = 3'd5;
   localparam logic [2:0] SEL_MD_OUT = 3'd6;
   localparam logic [2:0] SEL_MDO_M  = 3'd7;

   logic [4:0]       e_rs_q, e_rs_d, e_rt_q, e_rt_d, e_dst_q, e_dst_d;
   logic [1:0]       e_tnew_q, e_tnew_d, e_src_q, e_src_d, e_md_op_q, e_md_op_d;
   logic [4:0]       m_rt_q, m_rt_d, m_dst_q, m_dst_d;
   logic [1:0]       m_tnew_q, m_tnew_d, m_src_q, m_src_d;
   logic [4:0]       w_dst_q, w_dst_d;
   logic [1:0]       w_src_q, w_src_d;
   logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;

   function automatic logic [2:0] enc_m(input logic [1:0] src);
      case (src)
         SRC_ALU: enc_m = SEL_AO_M;
         SRC_PC8: enc_m = SEL_PC8_M;
         SRC_MD:  enc_m = SEL_MDO_M;
         default: enc_m = SEL_REG;
      endcase
   endfunction

   function automatic logic [2:0] enc_w(input logic [1:0] src);
      enc_w = (src == SRC_PC8) ? SEL_PC8_W : SEL_WD;
   endfunction

   function automatic logic [2:0] enc_e(input logic [1:0] src);
      case (src)
         SRC_PC8: enc_e = SEL_PC8_E;
         SRC_MD:  enc_e = SEL_MD_OUT;
         default: enc_e = SEL_REG;
      endcase
   endfunction

   // Register $0 never forwards and never stalls, which also makes bubbles (dst=0) inert.
   function automatic logic hazard(input logic [4:0] s, input logic [1:0] tuse,
                                   input logic [4:0] edst, input logic [1:0] etnew,
                                   input logic [4:0] mdst, input logic [1:0] mtnew);
      hazard = 1'b0;
      if (tuse != 2'd3 && s != 5'd0) begin
         if (edst == s && etnew > tuse) hazard = 1'b1;
         if (mdst == s && mtnew > tuse) hazard = 1'b1;
      end
   endfunction

   function automatic logic [2:0] sel_d(input logic [4:0] s,
                                        input logic [4:0] edst, input logic [1:0] esrc,
                                        input logic [4:0] mdst, input logic [1:0] msrc,
                                        input logic [4:0] wdst, input logic [1:0] wsrc);
      if (s == 5'd0)       sel_d = SEL_REG;
      else if (edst == s)  sel_d = enc_e(esrc);
      else if (mdst == s)  sel_d = enc_m(msrc);
      else if (wdst == s)  sel_d = enc_w(wsrc);
      else                 sel_d = SEL_REG;
   endfunction

   function automatic logic [2:0] sel_e(input logic [4:0] s,
                                        input logic [4:0] mdst, input logic [1:0] msrc,
                                        input logic [4:0] wdst, input logic [1:0] wsrc);
      if (s == 5'd0)       sel_e = SEL_REG;
      else if (mdst == s)  sel_e = enc_m(msrc);
      else if (wdst == s)  sel_e = enc_w(wsrc);
      else                 sel_e = SEL_REG;
   endfunction

   always_comb begin
      md_start = (e_md_op_q == MD_MULT) || (e_md_op_q == MD_DIV);
      md_busy  = (busy_cnt_q != '0) || md_start;
      stall    = hazard(rs_d, tuse_rs_d, e_dst_q, e_tnew_q, m_dst_q, m_tnew_q)
               | hazard(rt_d, tuse_rt_d, e_dst_q, e_tnew_q, m_dst_q, m_tnew_q)
               | (md_use_d && (md_start || busy_cnt_q != '0));
      fwd_rsd  = sel_d(rs_d, e_dst_q, e_src_q, m_dst_q, m_src_q, w_dst_q, w_src_q);
      fwd_rtd  = sel_d(rt_d, e_dst_q, e_src_q, m_dst_q, m_src_q, w_dst_q, w_src_q);
      fwd_rse  = sel_e(e_rs_q, m_dst_q, m_src_q, w_dst_q, w_src_q);
      fwd_rte  = sel_e(e_rt_q, m_dst_q, m_src_q, w_dst_q, w_src_q);
      if (m_rt_q != 5'd0 && w_dst_q == m_rt_q) fwd_rtm = enc_w(w_src_q);
      else                                     fwd_rtm = SEL_REG;
   end

   always_comb begin
      m_rt_d   = e_rt_q;
      m_dst_d  = e_dst_q;
      m_tnew_d = (e_tnew_q != 2'd0) ? e_tnew_q - 2'd1 : 2'd0;
      m_src_d  = e_src_q;
      w_dst_d  = m_dst_q;
      w_src_d  = m_src_q;

      e_rs_d    = 5'd0;
      e_rt_d    = 5'd0;
      e_dst_d   = 5'd0;
      e_tnew_d  = 2'd0;
      e_src_d   = 2'd0;
      e_md_op_d = 2'd0;
      if (!stall) begin
         e_rs_d    = rs_d;
         e_rt_d    = rt_d;
         e_dst_d   = dst_d;
         e_tnew_d  = tnew_d;
         e_src_d   = src_d;
         e_md_op_d = md_op_d;
      end

      // A start always (re)loads the latency, even if the unit is still busy.
      if (md_start)
         busy_cnt_d = (e_md_op_q == MD_DIV) ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
      else if (busy_cnt_q != '0)
         busy_cnt_d = busy_cnt_q - CNT_W'(1);
      else
         busy_cnt_d = '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         e_rs_q     <= 5'd0;
         e_rt_q     <= 5'd0;
         e_dst_q    <= 5'd0;
         e_tnew_q   <= 2'd0;
         e_src_q    <= 2'd0;
         e_md_op_q  <= 2'd0;
         m_rt_q     <= 5'd0;
         m_dst_q    <= 5'd0;
         m_tnew_q   <= 2'd0;
         m_src_q    <= 2'd0;
         w_dst_q    <= 5'd0;
         w_src_q    <= 2'd0;
         busy_cnt_q <= '0;
      end else begin
         e_rs_q     <= e_rs_d;
         e_rt_q     <= e_rt_d;
         e_dst_q    <= e_dst_d;
         e_tnew_q   <= e_tnew_d;
         e_src_q    <= e_src_d;
         e_md_op_q  <= e_md_op_d;
         m_rt_q     <= m_rt_d;
         m_dst_q    <= m_dst_d;
         m_tnew_q   <= m_tnew_d;
         m_src_q    <= m_src_d;
         w_dst_q    <= w_dst_d;
         w_src_q    <= w_src_d;
         busy_cnt_q <= busy_cnt_d;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: instruction sequences driven into D, selects/stall checked mid-cycle.
module tb_hazard_ctrl;

   logic       clk;
   logic       reset_n;
   logic [4:0] rs_d, rt_d, dst_d;
   logic [1:0] tuse_rs_d, tuse_rt_d, tnew_d, src_d, md_op_d;
   logic       md_use_d;
   logic       stall, md_start, md_busy;
   logic [2:0] fwd_rsd, fwd_rtd, fwd_rse, fwd_rte, fwd_rtm;

   int total = 0;
   int bad   = 0;

   hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
      .clk(clk), .reset_n(reset_n),
      .rs_d(rs_d), .rt_d(rt_d), .tuse_rs_d(tuse_rs_d), .tuse_rt_d(tuse_rt_d),
      .dst_d(dst_d), .tnew_d(tnew_d), .src_d(src_d),
      .md_use_d(md_use_d), .md_op_d(md_op_d),
      .stall(stall), .fwd_rsd(fwd_rsd), .fwd_rtd(fwd_rtd), .fwd_rse(fwd_rse),
      .fwd_rte(fwd_rte), .fwd_rtm(fwd_rtm), .md_start(md_start), .md_busy(md_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic set_d(input logic [4:0] rs, input logic [4:0] rt,
                        input logic [1:0] trs, input logic [1:0] trt,
                        input logic [4:0] dst, input logic [1:0] tnew,
                        input logic [1:0] src, input logic mduse, input logic [1:0] mdop);
      rs_d = rs; rt_d = rt; tuse_rs_d = trs; tuse_rt_d = trt;
      dst_d = dst; tnew_d = tnew; src_d = src; md_use_d = mduse; md_op_d = mdop;
      #2;
   endtask

   task automatic nop();
      set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 2'd0, 1'b0, 2'd0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic flush();
      nop();
      for (int i = 0; i < 3; i++) tick();
   endtask

   task automatic all_zero(input string tag);
      chk1({tag, "_stall"}, stall, 1'b0);
      chk3({tag, "_rsd"}, fwd_rsd, 3'd0);
      chk3({tag, "_rtd"}, fwd_rtd, 3'd0);
      chk3({tag, "_rse"}, fwd_rse, 3'd0);
      chk3({tag, "_rte"}, fwd_rte, 3'd0);
      chk3({tag, "_rtm"}, fwd_rtm, 3'd0);
      chk1({tag, "_busy"}, md_busy, 1'b0);
      chk1({tag, "_start"}, md_start, 1'b0);
   endtask

   initial begin
      reset_n = 1'b0;
      // Reset with random D-stage inputs
      for (int i = 0; i < 3; i++) begin
         set_d(5'($urandom), 5'($urandom), 2'($urandom), 2'($urandom), 5'($urandom),
               2'($urandom), 2'($urandom), 1'($urandom), 2'($urandom));
         all_zero("rst");
         tick();
      end
      nop();
      reset_n = 1'b1;
      tick();
      all_zero("post_rst");

      // lw $8 ; addu $9,$8,$1
      set_d(5'd1, 5'd0, 2'd1, 2'd3, 5'd8, 2'd2, 2'd1, 1'b0, 2'd0);
      tick();
      set_d(5'd8, 5'd1, 2'd1, 2'd1, 5'd9, 2'd1, 2'd0, 1'b0, 2'd0);
      chk1("lu_stall1", stall, 1'b1);
      chk3("lu_rsd1", fwd_rsd, 3'd0);
      tick();
      chk1("lu_stall2", stall, 1'b0);
      chk3("lu_rsd2", fwd_rsd, 3'd0);
      tick();
      nop();
      chk3("lu_rse", fwd_rse, 3'd2);
      flush();

      // jal ; jr $31 ; addu $2,$31,$0
      set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd31, 2'd0, 2'd2, 1'b0, 2'd0);
      tick();
      set_d(5'd31, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 2'd0, 1'b0, 2'd0);
      chk1("jr_stall", stall, 1'b0);
      chk3("jr_rsd", fwd_rsd, 3'd3);
      tick();
      set_d(5'd31, 5'd0, 2'd1, 2'd1, 5'd2, 2'd1, 2'd0, 1'b0, 2'd0);
      chk1("jal_m_stall", stall, 1'b0);
      chk3("jal_m_rsd", fwd_rsd, 3'd4);
      chk3("jal_m_rse", fwd_rse, 3'd4);
      tick();
      nop();
      chk3("jal_w_rse", fwd_rse, 3'd5);
      flush();

      // addu $5 ; sw $5 back-to-back
      set_d(5'd1, 5'd2, 2'd1, 2'd1, 5'd5, 2'd1, 2'd0, 1'b0, 2'd0);
      tick();
      set_d(5'd29, 5'd5, 2'd1, 2'd2, 5'd0, 2'd0, 2'd0, 1'b0, 2'd0);
      chk1("sw_stall", stall, 1'b0);
      chk3("sw_rtd_e", fwd_rtd, 3'd0);
      tick();
      nop();
      chk3("sw_rte", fwd_rte, 3'd1);
      tick();
      chk3("sw_rtm", fwd_rtm, 3'd2);
      flush();

      // addu $5 ; nop ; sw $5
      set_d(5'd1, 5'd2, 2'd1, 2'd1, 5'd5, 2'd1, 2'd0, 1'b0, 2'd0);
      tick();
      nop();
      tick();
      set_d(5'd29, 5'd5, 2'd1, 2'd2, 5'd0, 2'd0, 2'd0, 1'b0, 2'd0);
      chk3("sw_rtd_m", fwd_rtd, 3'd1);
      tick();
      nop();
      chk3("sw_rte_w", fwd_rte, 3'd2);
      flush();

      // mult ; mflo $10 ; addu $11,$10,$0
      set_d(5'd4, 5'd5, 2'd1, 2'd1, 5'd0, 2'd0, 2'd0, 1'b1, 2'd1);
      chk1("mult_stall", stall, 1'b0);
      tick();
      set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd10, 2'd0, 2'd3, 1'b1, 2'd0);
      for (int i = 0; i < 6; i++) begin
         chk1($sformatf("md_stall%0d", i), stall, 1'b1);
         chk1($sformatf("md_busy%0d", i), md_busy, 1'b1);
         chk1($sformatf("md_start%0d", i), md_start, (i == 0));
         tick();
      end
      chk1("md_stall_end", stall, 1'b0);
      chk1("md_busy_end", md_busy, 1'b0);
      chk1("md_start_end", md_start, 1'b0);
      tick();
      set_d(5'd10, 5'd0, 2'd1, 2'd1, 5'd11, 2'd1, 2'd0, 1'b0, 2'd0);
      chk1("mflo_stall", stall, 1'b0);
      chk3("mflo_rsd", fwd_rsd, 3'd6);
      tick();
      nop();
      chk3("mflo_rse", fwd_rse, 3'd7);
      flush();

      // mthi never sets busy
      set_d(5'd3, 5'd0, 2'd1, 2'd3, 5'd0, 2'd0, 2'd0, 1'b1, 2'd3);
      tick();
      set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd10, 2'd0, 2'd3, 1'b1, 2'd0);
      chk1("mthi_start", md_start, 1'b0);
      chk1("mthi_busy", md_busy, 1'b0);
      chk1("mthi_stall", stall, 1'b0);
      flush();

      // lw $0 ; reader of $0
      set_d(5'd1, 5'd0, 2'd1, 2'd3, 5'd0, 2'd2, 2'd1, 1'b0, 2'd0);
      tick();
      set_d(5'd0, 5'd0, 2'd0, 2'd0, 5'd3, 2'd1, 2'd0, 1'b0, 2'd0);
      chk1("r0_stall", stall, 1'b0);
      chk3("r0_rsd", fwd_rsd, 3'd0);
      chk3("r0_rtd", fwd_rtd, 3'd0);
      flush();

      // div, then asynchronous reset while busy
      set_d(5'd4, 5'd5, 2'd1, 2'd1, 5'd0, 2'd0, 2'd0, 1'b1, 2'd2);
      tick();
      nop();
      tick();
      set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd10, 2'd0, 2'd3, 1'b1, 2'd0);
      chk1("div_busy", md_busy, 1'b1);
      chk1("div_stall", stall, 1'b1);
      reset_n = 1'b0;
      #1;
      chk1("arst_busy", md_busy, 1'b0);
      chk1("arst_stall", stall, 1'b0);
      nop();
      reset_n = 1'b1;
      tick();
      all_zero("after_arst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
